// File: rtl/system_0_sysid_checker_pkg.sv
// System ID checker shared definitions: FSM state encoding, slave word
// addresses and the stall counter width.
package system_0_sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/system_0_sysid_checker.sv
// System ID checker: reads the ID word (address 0) and the timestamp word
// (address 1) from an Avalon-MM sysid slave and compares them with the
// expected values. Every output is registered from the next-state logic.
//
// Optional feature: define SYSID_CHECKER_TIMEOUT_EN to abort a read that
// has been stalled by waitrequest for TIMEOUT_CYCLES consecutive cycles.
// Without the macro a read waits forever and timeout is tied to 0.
module system_0_sysid_checker
  import system_0_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1563219222,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  // A timeout budget outside 1..65535 cannot be represented by the counter.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in the range 1..65535");
  end

  state_t      state;
  state_t      state_next;
  logic        avm_address_next;
  logic        avm_read_next;
  logic        id_ok_next;
  logic        ts_ok_next;
  logic [31:0] read_id_next;
  logic [31:0] read_ts_next;
  logic        rd_accept;
  logic        timeout_hit;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_next;
  logic                  timeout_q;
  logic                  timeout_next;
`endif

  assign rd_accept = avm_read && !avm_waitrequest;

  // Stall watchdog: fires on the cycle that would be the last allowed stall.
`ifdef SYSID_CHECKER_TIMEOUT_EN
  always_comb begin
    timeout_hit = avm_read && avm_waitrequest && (wait_cnt == TIMEOUT_LAST);
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Next-state and next-output decode; results hold unless a transition updates them.
  always_comb begin
    state_next       = state;
    avm_address_next = ADDR_ID;
    avm_read_next    = 1'b0;
    id_ok_next       = id_ok;
    ts_ok_next       = ts_ok;
    read_id_next     = read_id;
    read_ts_next     = read_ts;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    wait_cnt_next    = wait_cnt;
    timeout_next     = timeout_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_next       = RD_ID;
          avm_read_next    = 1'b1;
          avm_address_next = ADDR_ID;
          id_ok_next       = 1'b0;
          ts_ok_next       = 1'b0;
          read_id_next     = '0;
          read_ts_next     = '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          wait_cnt_next    = '0;
          timeout_next     = 1'b0;
`endif
        end
      end

      RD_ID: begin
        avm_read_next    = 1'b1;
        avm_address_next = ADDR_ID;
        if (rd_accept) begin
          state_next       = RD_TS;
          avm_address_next = ADDR_TS;
          read_id_next     = avm_readdata;
          id_ok_next       = (avm_readdata == EXPECTED_ID);
`ifdef SYSID_CHECKER_TIMEOUT_EN
          wait_cnt_next    = '0;
`endif
        end else if (timeout_hit) begin
          state_next       = DONE;
          avm_read_next    = 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          timeout_next     = 1'b1;
`endif
        end else begin
`ifdef SYSID_CHECKER_TIMEOUT_EN
          wait_cnt_next    = wait_cnt + WAIT_CNT_W'(1);
`endif
        end
      end

      RD_TS: begin
        avm_read_next    = 1'b1;
        avm_address_next = ADDR_TS;
        if (rd_accept) begin
          state_next       = DONE;
          avm_read_next    = 1'b0;
          avm_address_next = ADDR_ID;
          read_ts_next     = avm_readdata;
          ts_ok_next       = (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (timeout_hit) begin
          state_next       = DONE;
          avm_read_next    = 1'b0;
          avm_address_next = ADDR_ID;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          timeout_next     = 1'b1;
`endif
        end else begin
`ifdef SYSID_CHECKER_TIMEOUT_EN
          wait_cnt_next    = wait_cnt + WAIT_CNT_W'(1);
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy and done are decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
    end else begin
      state       <= state_next;
      avm_address <= avm_address_next;
      avm_read    <= avm_read_next;
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
      id_ok       <= id_ok_next;
      ts_ok       <= ts_ok_next;
      read_id     <= read_id_next;
      read_ts     <= read_ts_next;
    end
  end

`ifdef SYSID_CHECKER_TIMEOUT_EN
  // Stall counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      timeout_q <= timeout_next;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/system_0_sysid_checker.md
SYSTEM_0_SYSID_CHECKER -- requirements
Module: system_0_sysid_checker

Interface
REQ-001 The block SHALL take parameter EXPECTED_ID, default 32'h0000_0000, as the system ID value expected at slave word address 0.
REQ-002 The block SHALL take parameter EXPECTED_TIMESTAMP, default 32'd1563219222, as the timestamp expected at slave word address 1.
REQ-003 The block SHALL take parameter TIMEOUT_CYCLES, default 255 (range 1..65535), as the maximum number of waitrequest-stalled cycles per read.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request to run one check, sampled only in IDLE.
REQ-007 The block SHALL have port avm_address, output, 1 bit, the Avalon-MM word address.
REQ-008 The block SHALL have port avm_read, output, 1 bit, the Avalon-MM read strobe.
REQ-009 The block SHALL have port avm_readdata, input, 32 bits, the slave read data.
REQ-010 The block SHALL have port avm_waitrequest, input, 1 bit, the slave stall; tie it to 0 for a zero-wait slave.
REQ-011 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a check completes.
REQ-013 The block SHALL have ports id_ok, ts_ok and timeout, outputs, 1 bit each, the sticky result flags.
REQ-014 The block SHALL have ports read_id and read_ts, outputs, 32 bits each, the captured words.

Function
REQ-015 The FSM SHALL have states IDLE, RD_ID, RD_TS and DONE; all outputs are registered.
REQ-016 In IDLE, start=1 SHALL clear id_ok, ts_ok, timeout, read_id and read_ts and move the FSM to RD_ID.
REQ-017 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0.
REQ-018 In RD_TS, the block SHALL drive avm_read=1 and avm_address=1.
REQ-019 In IDLE and DONE, the block SHALL drive avm_read=0 and avm_address=0.
REQ-020 A read SHALL complete on the first cycle where avm_read=1 and avm_waitrequest=0; avm_readdata is captured in that cycle.
REQ-021 avm_address and avm_read SHALL remain stable while avm_waitrequest=1.
REQ-022 On RD_ID completion, the block SHALL set read_id to the captured data and id_ok=(data==EXPECTED_ID), then go to RD_TS.
REQ-023 On RD_TS completion, the block SHALL set read_ts to the captured data and ts_ok=(data==EXPECTED_TIMESTAMP), then go to DONE.
REQ-024 In DONE, the block SHALL assert done=1 for exactly one cycle and return to IDLE; result flags hold until the next accepted start.
REQ-025 With zero wait states and start sampled at edge N, avm_read SHALL be high in cycles N+1 and N+2 and done SHALL be high in cycle N+3.
REQ-026 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued; start held high SHALL retrigger only from IDLE.
REQ-027 The block SHALL use a 16-bit wait counter, cleared on entry to each read state and incremented on each stalled cycle.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE in any state, including mid-read.
REQ-029 The same reset edge SHALL clear avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, read_id, read_ts and the wait counter to 0.
REQ-030 reset SHALL take priority over start.

Configuration
REQ-031 The timeout feature SHALL be compiled in only when macro SYSID_CHECKER_TIMEOUT_EN is defined.
REQ-032 With SYSID_CHECKER_TIMEOUT_EN defined, TIMEOUT_CYCLES consecutive stalled cycles in a read state SHALL deassert avm_read on the next cycle, set timeout=1, leave id_ok and ts_ok at 0, and go to DONE.
REQ-033 With SYSID_CHECKER_TIMEOUT_EN undefined, a read SHALL wait indefinitely, timeout SHALL be constant 0, and the wait counter SHALL be absent.

Structure
REQ-034 Package system_0_sysid_checker_pkg SHALL hold the state enum typedef, the address constants ADDR_ID=1'b0 and ADDR_TS=1'b1, and the wait counter width constant (16).
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Zero-wait slave returning 0 then 1563219222, start pulse -> done in cycle N+3, id_ok=1, ts_ok=1, timeout=0, read_ts=32'd1563219222.
REQ-037 Slave returning 32'h0000_0001 at address 0 -> id_ok=0, ts_ok=1, read_id=1.
REQ-038 waitrequest held 3 cycles on each read -> address and read stable throughout, done in cycle N+9, both flags ok.
REQ-039 With SYSID_CHECKER_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest stuck high -> timeout=1, id_ok=0, done pulses once, avm_read=0 afterwards.
REQ-040 reset asserted during RD_TS -> all outputs 0 next cycle; a subsequent start runs a full clean check.
REQ-041 start held high continuously -> back-to-back checks, each done separated by 3 cycles of busy, with no start queued mid-check.
